debug_controller: RTL and testbench
===================================

Name: debug_controller

Overview:
- UART-side debug/sequencing controller for the MIPS DataPath.
- Consumes bytes from the UART receiver and loads program words into instruction memory.
- Gates the datapath clock-enable for run or single-step, and streams the PC (plus optional cycle count) back through the UART transmitter.
- Sits between the UART rx/tx cores and the DataPath enable/reset/imem-write ports.

Parameters:
- IMEM_ADDR_W, 8, instruction-memory word-address width; max load = 2^IMEM_ADDR_W-1 words.
- ACK_BYTE, 8'h4B, byte sent after a completed load.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte, valid while rx_done=1.
- rx_done  input  1  one-cycle pulse, new byte available.
- tx_done  input  1  one-cycle pulse, transmitter finished current byte.
- halt  input  1  datapath reached halt instruction (level).
- pc  input  32  current datapath PC.
- tx_data  output  8  byte to transmit.
- tx_start  output  1  one-cycle pulse, start transmit of tx_data.
- cpu_en  output  1  datapath clock-enable.
- cpu_rst  output  1  datapath reset (PC to 0).
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  IMEM_ADDR_W  word address.
- imem_wdata  output  32  word to write.

Behaviour:
- All outputs registered.
- Reset values: tx_data=0, tx_start=0, cpu_en=0, cpu_rst=0, imem_we=0, imem_addr=0, imem_wdata=0, state=IDLE, byte/word counters=0. Reset mid-operation aborts any load, run or send immediately.
- States: IDLE, LOAD_CNT, LOAD_DATA, RUN, STEP, SEND.
- IDLE, on rx_done:
  - 'L'(8'h4C) -> LOAD_CNT.
  - 'R'(8'h52) -> RUN.
  - 'S'(8'h53) -> STEP.
  - Any other byte is ignored.
- LOAD_CNT:
  - cpu_rst=1 throughout LOAD_CNT and LOAD_DATA.
  - Next byte = word count N. N=0 -> IDLE with no ack.
  - Otherwise latch N, clear word index, clear cycle count -> LOAD_DATA.
- LOAD_DATA:
  - Bytes are assembled little-endian (first byte -> bits 7:0).
  - On the 4th byte: imem_we=1 for exactly one cycle, with imem_addr=word index and imem_wdata=assembled word; then the index increments.
  - After word N-1 is written: load tx_data=ACK_BYTE, tx_start pulse -> SEND (ack-only, no payload).
- RUN:
  - cpu_en=1 every cycle while halt=0.
  - On halt=1, or on rx_done with byte 'H'(8'h48): cpu_en=0 that same edge, snapshot pc -> SEND.
  - Other rx bytes are ignored in RUN.
  - If halt is already 1 on entry, cpu_en is never asserted.
- STEP:
  - cpu_en=1 for exactly one cycle (also when halt=1).
  - The following cycle snapshots pc -> SEND.
- SEND:
  - Payload is the PC snapshot, LSB first, 4 bytes.
  - tx_start pulses one cycle per byte. The next byte is issued on the cycle after tx_done.
  - After the last tx_done -> IDLE.
  - rx bytes are ignored while in SEND.
- Cycle counter: 32-bit, increments each cycle cpu_en=1, wraps at 2^32, cleared on entry to LOAD_DATA.
- Latency:
  - 'R'/'S' byte -> cpu_en high on the next cycle.
  - Halt -> first tx_start within 2 cycles.

Optional Feature:
- Macro: DEBUG_CYCLE_COUNT_EN.
- When defined: the SEND payload after RUN/STEP is 8 bytes, PC (LSB first) then cycle count (LSB first), both snapshotted at the same edge.
- When undefined: the counter is not synthesized and the payload is 4 bytes.
- The load ack is unaffected in both cases.

Decomposition:
- Package debug_pkg:
  - state encoding localparams;
  - command byte constants CMD_LOAD, CMD_RUN, CMD_STEP, CMD_HALT;
  - PAYLOAD_BYTES value per macro.
- One natural sub-module: debug_tx_serializer. It takes a 64-bit snapshot plus byte count, drives tx_data/tx_start, consumes tx_done, and returns done.

Test Plan:
- Load: 'L', 8'h02, bytes 78 56 34 12 EF BE AD DE -> imem_we pulses at addr0=32'h12345678 and addr1=32'hDEADBEEF; cpu_rst=1 throughout; then tx byte 8'h4B.
- Step: after the load, 'S' with pc=32'h00000004 -> exactly one cpu_en cycle; tx 04 00 00 00 (with the macro, followed by 01 00 00 00).
- Run/halt: 'R', halt raised after 10 cycles with pc=32'h00000028 -> cpu_en high 10 cycles; tx 28 00 00 00 (macro: count 8'h0B total incl. prior step, 0B 00 00 00).
- Abort: 'R' with halt=0, then 'H' 50 cycles later -> cpu_en drops the same edge; PC dump follows.
- Boundaries: 'L' 8'h00 -> no imem_we, no tx. Unknown byte 8'h41 in IDLE -> no output change.
- Reset: assert reset during the 3rd data byte of a load -> all outputs 0 the next cycle; a following 'S' behaves as from IDLE.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared constants and types for the UART debug controller.
// DEBUG_CYCLE_COUNT_EN widens the RUN/STEP dump to PC plus cycle count.
package debug_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_CNT  = 3'd1;
  localparam logic [2:0] ST_LOAD_DATA = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_STEP      = 3'd4;
  localparam logic [2:0] ST_SEND      = 3'd5;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int unsigned PAYLOAD_BYTES = 8;
`else
  localparam int unsigned PAYLOAD_BYTES = 4;
`endif

  // One transmit job: up to 8 bytes, LSB first.
  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  nbytes;
  } tx_req_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// Streams up to 8 bytes of a latched snapshot to the UART transmitter, LSB first,
// one tx_start per byte; done fires combinationally with the final tx_done.
module debug_tx_serializer
  import debug_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  tx_req_t    req,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       done
);

  logic [55:0] shreg;
  logic [3:0]  rem;
  logic        busy;

  assign done = busy && tx_done && (rem == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      shreg    <= '0;
      rem      <= 4'd0;
      busy     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (start) begin
        tx_data  <= req.data[7:0];
        shreg    <= req.data[63:8];
        rem      <= req.nbytes - 4'd1;
        tx_start <= 1'b1;
        busy     <= 1'b1;
      end else if (busy && tx_done) begin
        if (rem == 4'd0) begin
          busy <= 1'b0;
        end else begin
          tx_data  <= shreg[7:0];
          shreg    <= {8'h00, shreg[55:8]};
          rem      <= rem - 4'd1;
          tx_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_controller.sv
// UART-side debug controller: loads imem words, runs/steps the datapath, dumps PC.
// Define DEBUG_CYCLE_COUNT_EN to append the 32-bit cpu_en cycle count to each dump.
module debug_controller
  import debug_pkg::*;
#(
  parameter int         IMEM_ADDR_W = 8,
  parameter logic [7:0] ACK_BYTE    = 8'h4B
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done,
  input  logic                   tx_done,
  input  logic                   halt,
  input  logic [31:0]            pc,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  output logic                   cpu_en,
  output logic                   cpu_rst,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata
);

  logic [2:0]             state, state_nxt;
  logic [7:0]             wcnt;
  logic [IMEM_ADDR_W-1:0] widx;
  logic [1:0]             bidx;
  logic [23:0]            wbuf;
  logic                   last_wr;
  logic                   last_word;
  logic                   stop;
  logic                   ser_start, ser_done;
  tx_req_t                ser_req;
  logic [31:0]            cyc_snap;

  assign stop      = halt || (rx_done && (rx_data == CMD_HALT));
  assign last_word = (32'(widx) == (32'(wcnt) - 32'd1));

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt, cyc_next;

  // Snapshot includes the increment of the edge that stops the core.
  assign cyc_next = cyc_cnt + {31'd0, cpu_en};
  assign cyc_snap = cyc_next;

  always_ff @(posedge clk) begin
    if (reset || (state == ST_LOAD_CNT && state_nxt == ST_LOAD_DATA))
      cyc_cnt <= 32'd0;
    else
      cyc_cnt <= cyc_next;
  end
`else
  assign cyc_snap = 32'd0;
`endif

  always_comb begin
    state_nxt = state;
    ser_start = 1'b0;
    ser_req   = '0;
    case (state)
      ST_IDLE: begin
        if (rx_done) begin
          case (rx_data)
            CMD_LOAD: state_nxt = ST_LOAD_CNT;
            CMD_RUN:  state_nxt = ST_RUN;
            CMD_STEP: state_nxt = ST_STEP;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_CNT: begin
        if (rx_done) state_nxt = (rx_data == 8'h00) ? ST_IDLE : ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        if (last_wr) begin
          state_nxt      = ST_SEND;
          ser_start      = 1'b1;
          ser_req.data   = {56'd0, ACK_BYTE};
          ser_req.nbytes = 4'd1;
        end
      end
      ST_RUN, ST_STEP: begin
        if (state == ST_STEP || stop) begin
          state_nxt      = ST_SEND;
          ser_start      = 1'b1;
          ser_req.data   = {cyc_snap, pc};
          ser_req.nbytes = 4'(PAYLOAD_BYTES);
        end
      end
      ST_SEND: begin
        if (ser_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cpu_en     <= 1'b0;
      cpu_rst    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      wcnt       <= 8'd0;
      widx       <= '0;
      bidx       <= 2'd0;
      wbuf       <= 24'd0;
      last_wr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cpu_rst <= (state_nxt == ST_LOAD_CNT) || (state_nxt == ST_LOAD_DATA);
      cpu_en  <= 1'b0;
      imem_we <= 1'b0;
      last_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A run entered with halt already high never enables the core.
          if (rx_done && (rx_data == CMD_STEP || (rx_data == CMD_RUN && !halt)))
            cpu_en <= 1'b1;
        end
        ST_LOAD_CNT: begin
          if (rx_done) begin
            wcnt <= rx_data;
            widx <= '0;
            bidx <= 2'd0;
          end
        end
        ST_LOAD_DATA: begin
          if (rx_done && !last_wr) begin
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= widx;
              imem_wdata <= {rx_data, wbuf};
              widx       <= widx + IMEM_ADDR_W'(1);
              last_wr    <= last_word;
            end else begin
              wbuf <= {rx_data, wbuf[23:8]};
            end
          end
        end
        ST_RUN: cpu_en <= !stop;
        default: ;
      endcase
    end
  end

  debug_tx_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .start    (ser_start),
    .req      (ser_req),
    .tx_done  (tx_done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_debug_controller.sv
// Scoreboarded bench for debug_controller: load, step, run/halt, abort, reset cases.
module tb_debug_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [7:0]  tx_data;
  logic        tx_start, cpu_en, cpu_rst, imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  int we_seen = 0;
  int en_cnt = 0;
  int tx_wait = -1;

  logic [7:0]  exp_tx[$];
  logic [39:0] exp_we[$];
  logic [7:0]  e_tx;
  logic [39:0] e_we;

  always #5 clk = ~clk;

  debug_controller dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .tx_done    (tx_done),
    .halt       (halt),
    .pc         (pc),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .cpu_en     (cpu_en),
    .cpu_rst    (cpu_rst),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata)
  );

  // UART tx model plus scoreboard pops, all on the negative edge.
  always @(negedge clk) begin
    if (tx_done) tx_done = 1'b0;
    if (reset) tx_wait = -1;
    else if (tx_wait > 0) tx_wait = tx_wait - 1;
    else if (tx_wait == 0) begin tx_done = 1'b1; tx_wait = -1; end
    if (cpu_en) en_cnt++;
    if (tx_start) begin
      tx_seen++;
      tx_wait = 3;
      checks++;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got %02h, no byte expected", tx_data);
      end else begin
        e_tx = exp_tx.pop_front();
        if (tx_data !== e_tx) begin
          errors++;
          $display("FAIL tx_byte: got %02h, required %02h", tx_data, e_tx);
        end
      end
    end
    if (imem_we) begin
      we_seen++;
      checks++;
      if (exp_we.size() == 0) begin
        errors++;
        $display("FAIL imem_unexpected: got addr %02h data %08h", imem_addr, imem_wdata);
      end else begin
        e_we = exp_we.pop_front();
        if ({imem_addr, imem_wdata} !== e_we) begin
          errors++;
          $display("FAIL imem_write: got %02h/%08h, required %02h/%08h",
                   imem_addr, imem_wdata, e_we[39:32], e_we[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'((w >> (8 * i)) & 32'hFF));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_we.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (exp_tx.size() != 0 || exp_we.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d tx / %0d writes pending, required 0",
               name, exp_tx.size(), exp_we.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [7:0] got [7];
    got[0] = tx_data; got[1] = {7'd0, tx_start}; got[2] = {7'd0, cpu_en};
    got[3] = {7'd0, cpu_rst}; got[4] = {7'd0, imem_we}; got[5] = imem_addr;
    got[6] = (imem_wdata != 32'd0) ? 8'h01 : 8'h00;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== 8'h00) begin
        errors++;
        $display("FAIL %s_out%0d: got %02h, required 00", name, i, got[i]);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_unknown;
    int t0 = tx_seen;
    int w0 = we_seen;
    send_byte(8'h41);
    repeat (4) @(negedge clk);
    #1;
    checks += 3;
    if (cpu_en !== 1'b0 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL unknown_ctrl: got en=%b rst=%b, required 0 0", cpu_en, cpu_rst);
    end
    if (tx_seen != t0) begin
      errors++;
      $display("FAIL unknown_tx: got %0d tx, required 0", tx_seen - t0);
    end
    if (we_seen != w0) begin
      errors++;
      $display("FAIL unknown_we: got %0d writes, required 0", we_seen - w0);
    end
  endtask

  task automatic test_load_zero;
    int t0 = tx_seen;
    int w0 = we_seen;
    send_byte(8'h4C);
    #1;
    checks++;
    if (cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL lz_rst: got %b, required 1", cpu_rst);
    end
    send_byte(8'h00);
    repeat (6) @(negedge clk);
    #1;
    checks += 3;
    if (cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL lz_rst_end: got %b, required 0", cpu_rst);
    end
    if (tx_seen != t0) begin
      errors++;
      $display("FAIL lz_tx: got %0d tx, required 0", tx_seen - t0);
    end
    if (we_seen != w0) begin
      errors++;
      $display("FAIL lz_we: got %0d writes, required 0", we_seen - w0);
    end
  endtask

  task automatic test_load;
    logic [7:0] bytes [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int w0 = we_seen;
    exp_we.push_back({8'h00, 32'h12345678});
    exp_we.push_back({8'h01, 32'hDEADBEEF});
    exp_tx.push_back(8'h4B);
    send_byte(8'h4C);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      #1;
      checks++;
      if (cpu_rst !== 1'b1) begin
        errors++;
        $display("FAIL load_rst_b%0d: got %b, required 1", i, cpu_rst);
      end
    end
    wait_drain("load");
    checks += 2;
    if (we_seen - w0 != 2) begin
      errors++;
      $display("FAIL load_we_count: got %0d, required 2", we_seen - w0);
    end
    if (cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL load_rst_end: got %b, required 0", cpu_rst);
    end
  endtask

  task automatic test_step;
    pc = 32'h00000004;
    push_word(32'h00000004);
`ifdef DEBUG_CYCLE_COUNT_EN
    push_word(32'h00000001);
`endif
    en_cnt = 0;
    send_byte(8'h53);
    #1;
    checks++;
    if (cpu_en !== 1'b1) begin
      errors++;
      $display("FAIL step_latency: got cpu_en=%b, required 1", cpu_en);
    end
    wait_drain("step");
    checks++;
    if (en_cnt != 1) begin
      errors++;
      $display("FAIL step_en_cycles: got %0d, required 1", en_cnt);
    end
  endtask

  task automatic test_run_halt;
    pc = 32'h00000028;
    push_word(32'h00000028);
`ifdef DEBUG_CYCLE_COUNT_EN
    push_word(32'h0000000B);
`endif
    en_cnt = 0;
    send_byte(8'h52);
    repeat (9) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    #1;
    checks += 2;
    if (cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL run_halt_en: got %b, required 0", cpu_en);
    end
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL run_halt_latency: got tx_start=%b, required 1", tx_start);
    end
    wait_drain("run");
    halt = 1'b0;
    checks++;
    if (en_cnt != 10) begin
      errors++;
      $display("FAIL run_en_cycles: got %0d, required 10", en_cnt);
    end
  endtask

  task automatic test_abort;
    pc = 32'h00000100;
    push_word(32'h00000100);
`ifdef DEBUG_CYCLE_COUNT_EN
    push_word(32'd61);
`endif
    en_cnt = 0;
    send_byte(8'h52);
    send_byte(8'h20);
    repeat (48) @(negedge clk);
    #1;
    checks++;
    if (cpu_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_running: got %b, required 1", cpu_en);
    end
    send_byte(8'h48);
    #1;
    checks++;
    if (cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_en_drop: got %b, required 0", cpu_en);
    end
    wait_drain("abort");
    checks++;
    if (en_cnt != 50) begin
      errors++;
      $display("FAIL abort_en_cycles: got %0d, required 50", en_cnt);
    end
  endtask

  task automatic test_reset_midload;
    int w0 = we_seen;
    send_byte(8'h4C);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_data = 8'h33;
    rx_done = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    #1;
    check_all_zero("midload");
    reset = 1'b0;
    @(negedge clk);
    pc = 32'h00000008;
    push_word(32'h00000008);
`ifdef DEBUG_CYCLE_COUNT_EN
    push_word(32'h00000001);
`endif
    en_cnt = 0;
    send_byte(8'h53);
    wait_drain("post_reset_step");
    checks += 2;
    if (en_cnt != 1) begin
      errors++;
      $display("FAIL post_reset_en: got %0d, required 1", en_cnt);
    end
    if (we_seen != w0) begin
      errors++;
      $display("FAIL midload_we: got %0d writes, required 0", we_seen - w0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unknown();
    test_load_zero();
    test_load();
    test_step();
    test_run_halt();
    test_abort();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
